ram8_scanner: RTL and testbench
===============================

# ram8_scanner

Initiator-side sequencer for the 8-word, 16-bit RAM8 port (in, load, address, out). On command it optionally fills all eight words with an incrementing pattern, then reads every word back in address order. Each read word is streamed out over a valid/ready handshake, and the block accumulates a 16-bit checksum of the words read. It sits between test or control logic and a RAM8 instance and owns that instance's in/load/address inputs.

## Interface
- No parameters. Depth is fixed at 8, data width at 16, address width at 3.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- start  in  1  command strobe; sampled only in IDLE.
- fill  in  1  sampled with start. 1 = fill then scan; 0 = scan only.
- fill_base  in  16  pattern base, sampled with start.
- ram_in  out  16  write data to RAM8 `in`.
- ram_load  out  1  write enable to RAM8 `load`.
- ram_address  out  3  to RAM8 `address`.
- ram_out  in  16  RAM8 `out`; combinational read of the word at ram_address.
- data_out  out  16  read-back word, registered.
- data_valid  out  1  data_out holds a word not yet accepted.
- data_ready  in  1  downstream accepts data_out.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- checksum  out  16  sum of words read in the current or last command, mod 2^16.

## Operation
- States: IDLE, FILL, READ, WAIT. There is a 3-bit address counter addr and a 16-bit base register.
- **IDLE**
  - start=1 latches fill_base, clears checksum, sets addr=0 and busy=1.
  - Next state is FILL if fill=1, otherwise READ.
- **FILL**
  - Drives ram_load=1, ram_address=addr, ram_in=base+addr (mod 2^16).
  - Each edge advances addr. The edge with addr=7 moves to READ with addr wrapped to 0.
- **READ**
  - Drives ram_load=0, ram_address=addr.
  - On the edge: data_out<=ram_out, data_valid<=1, checksum<=checksum+ram_out, then move to WAIT.
- **WAIT**
  - Holds ram_address=addr, data_out and data_valid.
  - On an edge with data_ready=1: data_valid<=0. If addr=7, go to IDLE with busy<=0 and done<=1; otherwise increment addr and go to READ.
  - While data_ready=0, the block stays in WAIT indefinitely with no output changes.
- Outside FILL: ram_load=0 and ram_in=0.
- start while busy is ignored. start and fill are not sampled in any state other than IDLE.
- checksum holds its final value until the next accepted start.
- Reset mid-command:
  - Everything returns to reset values at once and ram_load drops asynchronously.
  - RAM words written before the reset keep their contents.
  - No done pulse is produced.
- Reset values: state IDLE, addr 0, ram_in 0, ram_load 0, ram_address 0, data_out 0, data_valid 0, busy 0, done 0, checksum 0.

## Timing
- E0 is the edge that samples start=1. busy rises at E0.
- Fill writes happen at edges E1..E8, with addresses 0..7 in order and one write per cycle.
- With data_ready held high, each word takes 2 cycles (READ + WAIT).
- Word k appears on data_out at E(8+2k+1) with fill, or E(2k+1) without fill.
- done is high from E24 to E25 with fill, or E16 to E17 without. busy falls at the same edge done rises.
- A new start may be sampled on the cycle done is high, since the state is already IDLE.
- data_out changes only on a READ edge and is stable throughout WAIT.

## Test plan
- **Full fill + scan.** Start at E0 with fill=1, fill_base=15, data_ready=1 → RAM writes 15..22 at addresses 0..7, data_out sequence 15,16,…,22, checksum=148, done high at E24 only.
- **Scan only after fill.** Start with fill=0 → no ram_load pulses, same eight words and checksum 148, done at E16.
- **Backpressure.** data_ready=0 for 5 cycles on word 3 → data_out stays 18 and data_valid stays 1 throughout, addr stays 3, no other words are lost or repeated, and done is delayed 5 cycles.
- **Wrap arithmetic.** fill_base=16'hFFFC → words FFFC,FFFD,FFFE,FFFF,0000,0001,0002,0003 and checksum=16'hFFFC (mod 2^16).
- **Ignored start.** start pulsed during FILL and during WAIT → no restart and timing is unchanged.
- **Reset mid-FILL.** Reset after address 2 is written → all outputs go to 0 immediately. A following scan-only command returns the new values at addresses 0..2, and addresses 3..7 hold their prior contents.

Source files
------------

// File: rtl/ram8_scanner.sv
// Sequencer for an 8x16 RAM8 port: optional incrementing-pattern fill, then an
// in-order read-back streamed over valid/ready with a running 16-bit checksum.
module ram8_scanner (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_fill,
    input  logic [15:0] i_fill_base,
    output logic [15:0] o_ram_in,
    output logic        o_ram_load,
    output logic [2:0]  o_ram_address,
    input  logic [15:0] i_ram_out,
    output logic [15:0] o_data_out,
    output logic        o_data_valid,
    input  logic        i_data_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_checksum
);

    typedef enum logic [1:0] {IDLE, FILL, READ, WAIT} state_t;

    state_t      r_state;
    logic [2:0]  r_addr;
    logic [15:0] r_base;
    logic [15:0] r_ram_in;
    logic        r_ram_load;
    logic [15:0] r_data_out;
    logic        r_data_valid;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_checksum;

    logic [2:0]  w_addr_next;
    logic [15:0] w_fill_word;

    assign w_addr_next = r_addr + 3'd1;
    assign w_fill_word = r_base + {13'd0, w_addr_next};

    // ram_in/ram_load are registered one step ahead so they line up with the
    // address of the write that lands on the next edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_base       <= '0;
            r_ram_in     <= '0;
            r_ram_load   <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_checksum   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_base     <= i_fill_base;
                        r_checksum <= '0;
                        r_addr     <= '0;
                        r_busy     <= 1'b1;
                        if (i_fill) begin
                            r_state    <= FILL;
                            r_ram_load <= 1'b1;
                            r_ram_in   <= i_fill_base;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                FILL: begin
                    r_addr <= w_addr_next;
                    if (r_addr == 3'd7) begin
                        r_state    <= READ;
                        r_ram_load <= 1'b0;
                        r_ram_in   <= '0;
                    end else begin
                        r_ram_in <= w_fill_word;
                    end
                end
                READ: begin
                    r_data_out   <= i_ram_out;
                    r_data_valid <= 1'b1;
                    r_checksum   <= r_checksum + i_ram_out;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (i_data_ready) begin
                        r_data_valid <= 1'b0;
                        r_addr       <= w_addr_next;
                        if (r_addr == 3'd7) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ram_in      = r_ram_in;
    assign o_ram_load    = r_ram_load;
    assign o_ram_address = r_addr;
    assign o_data_out    = r_data_out;
    assign o_data_valid  = r_data_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_checksum    = r_checksum;

endmodule

// File: tb/tb_ram8_scanner.sv
// Bench for ram8_scanner: behavioural RAM8, scoreboard of expected read words,
// write-order monitor and done-timing checks relative to the start edge.
module tb_ram8_scanner;

    logic        i_clock;
    logic        i_reset;
    logic        i_start;
    logic        i_fill;
    logic [15:0] i_fill_base;
    logic [15:0] o_ram_in;
    logic        o_ram_load;
    logic [2:0]  o_ram_address;
    logic [15:0] w_ram_out;
    logic [15:0] o_data_out;
    logic        o_data_valid;
    logic        i_data_ready;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_checksum;

    ram8_scanner dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_fill        (i_fill),
        .i_fill_base   (i_fill_base),
        .o_ram_in      (o_ram_in),
        .o_ram_load    (o_ram_load),
        .o_ram_address (o_ram_address),
        .i_ram_out     (w_ram_out),
        .o_data_out    (o_data_out),
        .o_data_valid  (o_data_valid),
        .i_data_ready  (i_data_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_checksum    (o_checksum)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Behavioural RAM8: registered write, combinational read.
    logic [15:0] ram [8];
    always @(posedge i_clock) if (o_ram_load) ram[o_ram_address] <= o_ram_in;
    assign w_ram_out = ram[o_ram_address];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [15:0] exp_q [$];
    logic [15:0] exp_mem [8];
    int          wr_idx;
    logic        wr_fill;
    logic [15:0] wr_base;

    // Write-order and read-word monitor, sampled mid-cycle.
    always @(negedge i_clock) begin
        if (o_ram_load) begin
            if (!wr_fill) begin
                check("unexpected_load", {31'd0, o_ram_load}, {31'd0, wr_fill});
            end else begin
                check("wr_addr", {29'd0, o_ram_address}, {29'd0, wr_idx[2:0]});
                check("wr_data", {16'd0, o_ram_in}, {16'd0, 16'(wr_base + wr_idx)});
            end
            wr_idx++;
        end
        if (o_data_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_word", {31'd0, o_data_valid}, 32'd0);
            end else begin
                check(i_data_ready ? "rd_word" : "stall_word", {16'd0, o_data_out}, {16'd0, exp_q[0]});
                if (i_data_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Issue one command from just after a posedge and follow it to done.
    task automatic run_cmd(input logic f, input logic [15:0] base, input int stall_word,
                           input int stall_len, input bit ign);
        int          s;
        int          exp_done;
        int          done_at;
        logic [15:0] w;
        logic [15:0] sum;
        sum = '0;
        for (int k = 0; k < 8; k++) begin
            w = f ? 16'(base + k) : exp_mem[k];
            exp_q.push_back(w);
            sum = sum + w;
            if (f) exp_mem[k] = w;
        end
        wr_idx  = 0;
        wr_fill = f;
        wr_base = base;
        i_start = 1'b1; i_fill = f; i_fill_base = base;
        @(posedge i_clock); #1;
        i_start = 1'b0; i_fill = ~f; i_fill_base = ~base;
        check("busy_e0", {31'd0, o_busy}, 32'd1);
        s        = (f ? 8 : 0) + 2 * stall_word + 1;
        exp_done = (f ? 24 : 16) + stall_len;
        done_at  = -1;
        for (int c = 0; c < 100 && done_at < 0; c++) begin
            i_data_ready = !(stall_len > 0 && c >= s && c < s + stall_len);
            if (stall_len > 0 && c >= s && c <= s + stall_len) begin
                check("stall_valid", {31'd0, o_data_valid}, 32'd1);
                check("stall_addr", {29'd0, o_ram_address}, stall_word);
            end
            if (ign && (c == 3 || c == 9)) begin
                i_start = 1'b1; i_fill = 1'b1; i_fill_base = 16'h1234;
            end else begin
                i_start = 1'b0;
            end
            @(posedge i_clock); #1;
            if (o_done) done_at = c + 1;
        end
        i_start = 1'b0;
        check("done_edge", done_at, exp_done);
        check("busy_at_done", {31'd0, o_busy}, 32'd0);
        check("checksum", {16'd0, o_checksum}, {16'd0, sum});
        check("words_left", exp_q.size(), 32'd0);
        check("write_count", wr_idx, f ? 32'd8 : 32'd0);
        @(posedge i_clock); #1;
        check("done_pulse_end", {31'd0, o_done}, 32'd0);
        check("checksum_hold", {16'd0, o_checksum}, {16'd0, sum});
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_fill = 1'b0; i_fill_base = '0;
        i_data_ready = 1'b1; wr_idx = 0; wr_fill = 1'b0; wr_base = '0;
        #12;
        check("rst_ram_in", {16'd0, o_ram_in}, 32'd0);
        check("rst_ram_load", {31'd0, o_ram_load}, 32'd0);
        check("rst_addr", {29'd0, o_ram_address}, 32'd0);
        check("rst_data_out", {16'd0, o_data_out}, 32'd0);
        check("rst_valid", {31'd0, o_data_valid}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_checksum", {16'd0, o_checksum}, 32'd0);
        i_reset = 1'b0;
        @(posedge i_clock); #1;

        run_cmd(1'b1, 16'd15, 0, 0, 1'b0);
        check("sum_15", {16'd0, o_checksum}, 32'd148);
        run_cmd(1'b0, 16'd0, 0, 0, 1'b0);
        run_cmd(1'b0, 16'd0, 3, 5, 1'b0);
        run_cmd(1'b1, 16'hFFFC, 0, 0, 1'b0);
        check("sum_wrap", {16'd0, o_checksum}, 32'hFFFC);
        run_cmd(1'b1, 16'd15, 0, 0, 1'b1);

        // Reset while the fill is writing address 3; words 0..2 already landed.
        wr_idx = 0; wr_fill = 1'b1; wr_base = 16'd100;
        i_start = 1'b1; i_fill = 1'b1; i_fill_base = 16'd100;
        @(posedge i_clock); #1;
        i_start = 1'b0;
        repeat (3) @(posedge i_clock);
        #1 i_reset = 1'b1;
        #1;
        check("mid_ram_load", {31'd0, o_ram_load}, 32'd0);
        check("mid_ram_in", {16'd0, o_ram_in}, 32'd0);
        check("mid_addr", {29'd0, o_ram_address}, 32'd0);
        check("mid_busy", {31'd0, o_busy}, 32'd0);
        check("mid_done", {31'd0, o_done}, 32'd0);
        check("mid_valid", {31'd0, o_data_valid}, 32'd0);
        check("mid_checksum", {16'd0, o_checksum}, 32'd0);
        @(negedge i_clock);
        i_reset = 1'b0;
        check("mid_writes", wr_idx, 32'd3);
        for (int k = 0; k < 3; k++) exp_mem[k] = 16'(100 + k);
        @(posedge i_clock); #1;
        check("post_rst_done", {31'd0, o_done}, 32'd0);
        run_cmd(1'b0, 16'd0, 0, 0, 1'b0);
        check("sum_mixed", {16'd0, o_checksum}, 32'd403);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
